// File: rtl/clock_pkg.sv
// Shared timekeeping constants for the seconds, minute/hour and date stages.
package clock_pkg;

    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;
    localparam int HR_MAX  = 23;

    localparam int MIN_W   = 6;
    localparam int HR_W    = 5;
    localparam int DATA_W  = 6;

endpackage : clock_pkg

// File: rtl/wrap_counter.sv
// Binary counter 0..MAX with synchronous clear, range-checked load and increment-with-wrap.
module wrap_counter #(
    parameter int W   = 6,
    parameter int DW  = 6,
    parameter int MAX = 59
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          inhibit,
    input  logic          load,
    input  logic [DW-1:0] data,
    input  logic          inc,
    output logic [W-1:0]  cnt,
    output logic          at_max
);

    localparam logic [DW-1:0] MAX_D = DW'(MAX);
    localparam logic [W-1:0]  MAX_W = W'(MAX);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    // Next count: any load in the stage suppresses counting; out-of-range loads hold.
    always_comb begin
        cnt_d = cnt_q;
        if (inhibit) begin
            if (load && (data <= MAX_D)) begin
                cnt_d = data[W-1:0];
            end else begin
                cnt_d = cnt_q;
            end
        end else if (inc) begin
            if (cnt_q == MAX_W) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk) begin
        if (clear) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt    = cnt_q;
    assign at_max = (cnt_q == MAX_W);

endmodule : wrap_counter

// File: rtl/minute_hour_counter.sv
// Minutes/hours stage: counts seconds-wrap pulses, supports field loads,
// drives gated databus, 12-hour view and a midnight day_tick.
module minute_hour_counter
    import clock_pkg::*;
#(
    parameter int MIN_MAX = clock_pkg::MIN_MAX,
    parameter int HR_MAX  = clock_pkg::HR_MAX
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              sec_tick,
    input  logic              load_min,
    input  logic              load_hr,
    input  logic [DATA_W-1:0] data,
    input  logic              enable,
    output logic [MIN_W-1:0]  min,
    output logic [HR_W-1:0]   hr,
    output logic [MIN_W-1:0]  databus_min,
    output logic [HR_W-1:0]   databus_hr,
    output logic [3:0]        hr12,
    output logic              pm,
    output logic              day_tick
);

    logic any_load_s;
    logic min_at_max_s;
    logic hr_at_max_s;
    logic hr_inc_s;
    logic day_tick_d;
    logic day_tick_q;

    assign any_load_s = load_min | load_hr;
    assign hr_inc_s   = sec_tick & min_at_max_s & ~any_load_s;

    wrap_counter #(.W(MIN_W), .DW(DATA_W), .MAX(MIN_MAX)) u_min (
        .clk     (clk),
        .clear   (clear),
        .inhibit (any_load_s),
        .load    (load_min),
        .data    (data),
        .inc     (sec_tick),
        .cnt     (min),
        .at_max  (min_at_max_s)
    );

    wrap_counter #(.W(HR_W), .DW(DATA_W), .MAX(HR_MAX)) u_hr (
        .clk     (clk),
        .clear   (clear),
        .inhibit (any_load_s),
        .load    (load_hr),
        .data    (data),
        .inc     (hr_inc_s),
        .cnt     (hr),
        .at_max  (hr_at_max_s)
    );

    // Midnight wrap is detected from the pre-edge state so the pulse lines up with 00:00.
    always_comb begin
        day_tick_d = 1'b0;
        if (hr_inc_s && hr_at_max_s) begin
            day_tick_d = 1'b1;
        end else begin
            day_tick_d = 1'b0;
        end
    end

    // Day tick register; clear forces it low even on a simultaneous wrap.
    always_ff @(posedge clk) begin
        if (clear) begin
            day_tick_q <= 1'b0;
        end else begin
            day_tick_q <= day_tick_d;
        end
    end

    assign day_tick = day_tick_q;

    // 12-hour view: hour 0 displays as 12, afternoon hours fold down by 12.
    always_comb begin
        hr12 = 4'd12;
        pm   = 1'b0;
        if (hr == 5'd0) begin
            hr12 = 4'd12;
            pm   = 1'b0;
        end else if (hr < 5'd12) begin
            hr12 = 4'(hr);
            pm   = 1'b0;
        end else if (hr == 5'd12) begin
            hr12 = 4'd12;
            pm   = 1'b1;
        end else begin
            hr12 = 4'(hr - 5'd12);
            pm   = 1'b1;
        end
    end

    assign databus_min = min & {MIN_W{enable}};
    assign databus_hr  = hr  & {HR_W{enable}};

endmodule : minute_hour_counter

// File: tb/tb_minute_hour_counter.sv
// Directed vector bench for minute_hour_counter plus full-day run.
module tb_minute_hour_counter;

    logic       clk = 1'b0;
    logic       clear, sec_tick, load_min, load_hr, enable;
    logic [5:0] data;
    logic [5:0] min, databus_min;
    logic [4:0] hr, databus_hr;
    logic [3:0] hr12;
    logic       pm, day_tick;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    minute_hour_counter dut (
        .clk(clk), .clear(clear), .sec_tick(sec_tick), .load_min(load_min),
        .load_hr(load_hr), .data(data), .enable(enable), .min(min), .hr(hr),
        .databus_min(databus_min), .databus_hr(databus_hr), .hr12(hr12),
        .pm(pm), .day_tick(day_tick)
    );

    typedef struct {
        logic       clr, st, lm, lh;
        logic [5:0] d;
        logic       en;
        logic [5:0] emin;
        logic [4:0] ehr;
        logic [3:0] e12;
        logic       epm, edt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic clr, logic st, logic lm, logic lh, logic [5:0] d,
                                logic en, logic [5:0] emin, logic [4:0] ehr,
                                logic [3:0] e12, logic epm, logic edt);
        vec_t v;
        v.clr = clr; v.st = st; v.lm = lm; v.lh = lh; v.d = d; v.en = en;
        v.emin = emin; v.ehr = ehr; v.e12 = e12; v.epm = epm; v.edt = edt;
        return v;
    endfunction

    task automatic drive(logic clr, logic st, logic lm, logic lh, logic [5:0] d, logic en);
        @(negedge clk);
        clear = clr; sec_tick = st; load_min = lm; load_hr = lh; data = d; enable = en;
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(string name, vec_t v);
        logic [5:0] edbm;
        logic [4:0] edbh;
        edbm = v.en ? v.emin : 6'd0;
        edbh = v.en ? v.ehr : 5'd0;
        checks++;
        if (min !== v.emin || hr !== v.ehr || hr12 !== v.e12 || pm !== v.epm ||
            day_tick !== v.edt || databus_min !== edbm || databus_hr !== edbh) begin
            errors++;
            $display("FAIL %s: got min=%0d hr=%0d hr12=%0d pm=%0b dt=%0b dbm=%0d dbh=%0d, need min=%0d hr=%0d hr12=%0d pm=%0b dt=%0b dbm=%0d dbh=%0d",
                     name, min, hr, hr12, pm, day_tick, databus_min, databus_hr,
                     v.emin, v.ehr, v.e12, v.epm, v.edt, edbm, edbh);
        end
    endtask

    initial begin
        int dt_count;
        clear = 1'b0; sec_tick = 1'b0; load_min = 1'b0; load_hr = 1'b0;
        data = 6'd0; enable = 1'b1;

        //                clr   st    lm    lh    d      en    min    hr     12     pm    dt
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 6'd0,  5'd0,  4'd12, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 6'd58, 1'b1, 6'd58, 5'd0,  4'd12, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 6'd23, 1'b1, 6'd58, 5'd23, 4'd11, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 6'd0,  1'b1, 6'd59, 5'd23, 4'd11, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 6'd0,  1'b1, 6'd0,  5'd0,  4'd12, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 6'd0,  5'd0,  4'd12, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 6'd10, 1'b1, 6'd0,  5'd10, 4'd10, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 6'd59, 1'b1, 6'd59, 5'd10, 4'd10, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 6'd5,  1'b1, 6'd5,  5'd10, 4'd10, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 6'd30, 1'b1, 6'd5,  5'd10, 4'd10, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 6'd60, 1'b1, 6'd5,  5'd10, 4'd10, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 6'd35, 1'b1, 6'd35, 5'd10, 4'd10, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 6'd7,  1'b1, 6'd7,  5'd7,  4'd7,  1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 6'd0,  1'b1, 6'd7,  5'd0,  4'd12, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 6'd12, 1'b1, 6'd7,  5'd12, 4'd12, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 6'd13, 1'b1, 6'd7,  5'd13, 4'd1,  1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 6'd23, 1'b1, 6'd7,  5'd23, 4'd11, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 6'd14, 1'b1, 6'd7,  5'd14, 4'd2,  1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 6'd37, 1'b1, 6'd37, 5'd14, 4'd2,  1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 6'd37, 5'd14, 4'd2,  1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 6'd37, 5'd14, 4'd2,  1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 6'd59, 1'b1, 6'd59, 5'd14, 4'd2,  1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 6'd23, 1'b1, 6'd59, 5'd23, 4'd11, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 6'd0,  1'b1, 6'd0,  5'd0,  4'd12, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 6'd58, 1'b1, 6'd58, 5'd0,  4'd12, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 6'd0,  1'b1, 6'd59, 5'd0,  4'd12, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 6'd0,  1'b1, 6'd0,  5'd1,  4'd1,  1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 6'd0,  1'b1, 6'd1,  5'd1,  4'd1,  1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 6'd33, 1'b1, 6'd1,  5'd1,  4'd1,  1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  5'd0,  4'd12, 1'b0, 1'b0));

        foreach (vecs[i]) begin
            drive(vecs[i].clr, vecs[i].st, vecs[i].lm, vecs[i].lh, vecs[i].d, vecs[i].en);
            check_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Full day from 00:00: exactly one day_tick, landing on the final tick.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1);
        dt_count = 0;
        for (int t = 0; t < 1440; t++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b1);
            if (day_tick) dt_count++;
            if (t == 59) check_vec("one_hour", mk(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b1,
                                                  6'd0, 5'd1, 4'd1, 1'b0, 1'b0));
            if (t == 779) check_vec("thirteen_hr", mk(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b1,
                                                      6'd0, 5'd13, 4'd1, 1'b1, 1'b0));
        end
        check_vec("full_day", mk(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b1,
                                 6'd0, 5'd0, 4'd12, 1'b0, 1'b1));
        checks++;
        if (dt_count != 1) begin
            errors++;
            $display("FAIL day_tick_count: got %0d, need 1", dt_count);
        end

        // Multi-cycle sec_tick advances once per high cycle.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b1);
        check_vec("held_tick", mk(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b1,
                                  6'd2, 5'd0, 4'd12, 1'b0, 1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_minute_hour_counter
